// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_rx
// Purpose  : Serial-in / parallel-out receiver. Frames arrive MSB first on
//            sin, qualified by sin_en and delimited by start. Each completed
//            word goes into a one-deep output register that has a
//            valid/ready handshake. A completed word that finds that
//            register full (and not being consumed) is dropped, and
//            overrun pulses for one cycle.
// Macro    : SIPO_RX_PARITY_EN -- when defined, each frame carries one extra
//            even-parity bit after the N data bits, and the parity_err
//            output is added.
// Ports    : clk        rising-edge clock
//            rst        synchronous reset, active low
//            sin        serial data bit (MSB first)
//            sin_en     sin qualifier
//            start      marks the current sin bit as a frame MSB
//            dout       received word (N bits)
//            dout_valid dout holds an unconsumed word
//            dout_ready consumer accepts dout
//            busy       a frame is being shifted in
//            overrun    one-cycle pulse, a completed word was dropped
//            parity_err parity mismatch for dout (macro builds only)
// Revision : 1.0 - initial release
// ============================================================================
module sipo_rx #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         start,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         overrun
`ifdef SIPO_RX_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
`ifdef SIPO_RX_PARITY_EN
    localparam logic [1:0] c_st_parity = 2'd2;
`endif

    localparam logic [CW-1:0] c_cnt_zero = '0;
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    // Count value held before the edge that captures data bit N
    localparam logic [CW-1:0] c_cnt_last = CW'(N - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_shift;
    logic [N-1:0]  r_dout;
    logic          r_dout_valid;
    logic          r_overrun;

    logic          w_restart;
    logic          w_advance;
    logic          w_complete;
    logic [N-1:0]  w_word;
`ifdef SIPO_RX_PARITY_EN
    logic          r_parity_err;
    logic          w_perr;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A qualified start restarts from any state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (sin_en && start) begin
                    w_state_nxt = c_st_shift;
                end
            end
            c_st_shift: begin
                if (sin_en) begin
                    if (start) begin
                        w_state_nxt = c_st_shift;
                    end else if (r_count == c_cnt_last) begin
`ifdef SIPO_RX_PARITY_EN
                        w_state_nxt = c_st_parity;
`else
                        w_state_nxt = c_st_idle;
`endif
                    end
                end
            end
`ifdef SIPO_RX_PARITY_EN
            c_st_parity: begin
                if (sin_en) begin
                    w_state_nxt = start ? c_st_shift : c_st_idle;
                end
            end
`endif
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (r_state != c_st_idle);
        w_restart = sin_en && start;
        w_advance = sin_en && !start && (r_state == c_st_shift);
`ifdef SIPO_RX_PARITY_EN
        // The shift register is already full here. sin is the parity bit,
        // and even parity means the total count of ones must be even.
        w_complete = sin_en && !start && (r_state == c_st_parity);
        w_word     = r_shift;
        w_perr     = ^{r_shift, sin};
`else
        // The completing word includes the bit sampled on this very edge
        w_complete = w_advance && (r_count == c_cnt_last);
        w_word     = {r_shift[N-2:0], sin};
`endif
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter. The counter saturates at N because
    // the frame always leaves SHIFT on the edge that captures bit N.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_count <= c_cnt_zero;
        end else if (w_restart) begin
            r_shift <= {{(N-1){1'b0}}, sin};
            r_count <= c_cnt_one;
        end else if (w_advance) begin
            r_shift <= {r_shift[N-2:0], sin};
            r_count <= r_count + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Output register with valid/ready. A reload takes priority over a
    // plain consume on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_overrun <= w_complete && r_dout_valid && !dout_ready;
            if (w_complete && (!r_dout_valid || dout_ready)) begin
                r_dout       <= w_word;
                r_dout_valid <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
                r_parity_err <= w_perr;
`endif
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
`ifdef SIPO_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_rx
// Purpose  : Self-checking bench for sipo_rx with N=8. A frame-level model
//            (a bit queue plus output-register rules) tracks the expected
//            outputs, and a negedge process compares them every cycle.
//            Directed scenarios add literal expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_rx;

    localparam int N = 8;
`ifdef SIPO_RX_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic         clk;
    logic         rst;
    logic         sin;
    logic         sin_en;
    logic         start;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;
`ifdef SIPO_RX_PARITY_EN
    logic         parity_err;
`endif

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    sipo_rx #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .start      (start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun)
`ifdef SIPO_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    bit           mq[$];
    bit           m_in    = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_ovr   = 1'b0;
    bit           m_perr  = 1'b0;
    logic [N-1:0] m_dout  = '0;

    task automatic model_step(input logic r, input logic st, input logic en,
                              input logic s, input logic rdy);
        bit           cmp;
        bit           pe;
        logic [N-1:0] w;
        cmp = 1'b0;
        pe  = 1'b0;
        w   = '0;
        if (!r) begin
            mq.delete();
            m_in    = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
            m_dout  = '0;
            return;
        end
        if (en) begin
            if (st) begin
                mq.delete();
                mq.push_back(s);
                m_in = 1'b1;
            end else if (m_in) begin
                mq.push_back(s);
                if (mq.size() == FL) begin
                    cmp  = 1'b1;
                    m_in = 1'b0;
                    foreach (mq[k]) begin
                        if (k < N) w = {w[N-2:0], mq[k]};
                        pe = pe ^ mq[k];
                    end
                end
            end
        end
        m_ovr = 1'b0;
        if (cmp) begin
            if (!m_valid || rdy) begin
                m_dout  = w;
                m_valid = 1'b1;
                m_perr  = pe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
            m_perr  = 1'b0;
        end
    endtask

    // Compare at negedge, then advance the model with the inputs that the
    // next rising edge will sample (they are stable since posedge+1).
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("m_dout_valid", {31'b0, dout_valid}, {31'b0, m_valid});
                chk("m_busy",       {31'b0, busy},       {31'b0, m_in});
                chk("m_overrun",    {31'b0, overrun},    {31'b0, m_ovr});
                chk("m_dout",       32'(dout),           32'(m_dout));
`ifdef SIPO_RX_PARITY_EN
                chk("m_parity_err", {31'b0, parity_err}, {31'b0, m_perr});
`endif
                model_step(rst, start, sin_en, sin, dout_ready);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic st, input logic en,
                       input logic s, input logic rdy);
        rst        = r;
        start      = st;
        sin_en     = en;
        sin        = s;
        dout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    // Sends N data bits MSB first; parity builds add an even-parity bit,
    // optionally inverted.
    task automatic send_frame(input logic [N-1:0] w, input logic rdy, input logic flip);
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, (i == 0), 1'b1, w[N-1-i], rdy);
        end
`ifdef SIPO_RX_PARITY_EN
        cyc(1'b1, 1'b0, 1'b1, (^w) ^ flip, rdy);
`else
        if (flip) idle(rdy);
`endif
    endtask

    logic [N-1:0] tbl [5];

    initial begin
        tbl[0] = 8'h81; tbl[1] = 8'h7E; tbl[2] = 8'h00; tbl[3] = 8'hFF; tbl[4] = 8'h4D;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_valid",   {31'b0, dout_valid}, 32'd0);
        chk("rst_busy",    {31'b0, busy},       32'd0);
        chk("rst_overrun", {31'b0, overrun},    32'd0);
        chk("rst_dout",    32'(dout),           32'h0);

        // 8'hB2, ready high: valid the cycle after the last bit, for one cycle
        send_frame(8'hB2, 1'b1, 1'b0);
        chk("b2_valid", {31'b0, dout_valid}, 32'd1);
        chk("b2_dout",  32'(dout),           32'hB2);
        chk("b2_busy",  {31'b0, busy},       32'd0);
        idle(1'b1);
        chk("b2_clear", {31'b0, dout_valid}, 32'd0);

        // 8'hA5 with a 3-cycle stall after bit 4; start without sin_en ignored
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, (i == 0), 1'b1, tbl[0][0] ^ 1'b0 ? 1'b0 : 1'b0, 1'b1);
        end
        idle(1'b1);
        for (int i = 0; i < N; i++) begin
            logic [N-1:0] a5;
            a5 = 8'hA5;
            cyc(1'b1, (i == 0), 1'b1, a5[N-1-i], 1'b1);
            if (i == 3) begin
                cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
                chk("a5_stall_busy", {31'b0, busy}, 32'd1);
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
                chk("a5_stall_valid", {31'b0, dout_valid}, 32'd0);
            end
        end
`ifdef SIPO_RX_PARITY_EN
        cyc(1'b1, 1'b0, 1'b1, ^8'hA5, 1'b1);
`endif
        chk("a5_dout",  32'(dout),           32'hA5);
        chk("a5_valid", {31'b0, dout_valid}, 32'd1);
        idle(1'b1);

        // Overrun: 8'h3C then 8'hC3 with ready low
        idle(1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("ovr_first", 32'(dout), 32'h3C);
        send_frame(8'hC3, 1'b0, 1'b0);
        chk("ovr_pulse", {31'b0, overrun},   32'd1);
        chk("ovr_keep",  32'(dout),          32'h3C);
        idle(1'b0);
        chk("ovr_once",  {31'b0, overrun},   32'd0);
        chk("ovr_valid", {31'b0, dout_valid}, 32'd1);
        idle(1'b1);
        chk("ovr_clear", {31'b0, dout_valid}, 32'd0);

        // Abort: 8'hFF interrupted at bit 5 by frame 8'h01
        for (int i = 0; i < 4; i++) cyc(1'b1, (i == 0), 1'b1, 1'b1, 1'b1);
        send_frame(8'h01, 1'b1, 1'b0);
        chk("abort_dout", 32'(dout),        32'h01);
        chk("abort_ovr",  {31'b0, overrun}, 32'd0);
        idle(1'b1);

        // Reset at bit 6 (with start asserted, reset wins), then 8'h5A
        for (int i = 0; i < 5; i++) cyc(1'b1, (i == 0), 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_busy",  {31'b0, busy},       32'd0);
        chk("midrst_valid", {31'b0, dout_valid}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("midrst_dout", 32'(dout), 32'h5A);

        // Reset while a word is pending
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pendrst_valid", {31'b0, dout_valid}, 32'd0);
        chk("pendrst_ovr",   {31'b0, overrun},    32'd0);

        // Back-to-back frames, ready high: each reload on the completing edge
        for (int f = 0; f < 5; f++) begin
            send_frame(tbl[f], 1'b1, 1'b0);
            chk("b2b_dout", 32'(dout), 32'(tbl[f]));
        end
        idle(1'b1);

`ifdef SIPO_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_ok",  {31'b0, parity_err}, 32'd0);
        idle(1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_bad", {31'b0, parity_err}, 32'd1);
        idle(1'b1);
`endif

        idle(1'b1);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter N, default 64, frame width in bits; N >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 sin  input  1  serial data bit, MSB first.
REQ-005 sin_en  input  1  sin qualifier; sin is sampled only on edges where sin_en=1.
REQ-006 start  input  1  marks the bit on sin as a frame's MSB; honoured only with sin_en=1.
REQ-007 dout  output  N  received word, held stable while dout_valid=1.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1.
REQ-010 busy  output  1  a frame is being shifted in (state SHIFT or PARITY).
REQ-011 overrun  output  1  one-cycle pulse: a completed word was discarded.
REQ-012 parity_err  output  1  present only with SIPO_RX_PARITY_EN (REQ-030).

Function
REQ-013 States: IDLE, SHIFT, PARITY (PARITY only with SIPO_RX_PARITY_EN); separate N-bit shift register and N-bit output register.
REQ-014 IDLE: edge with start=1, sin_en=1 loads sin as the MSB, sets bit count to 1, enters SHIFT; sin ignored otherwise.
REQ-015 SHIFT: each edge with sin_en=1 shifts left, sin into LSB, count+1; sin_en=0 holds all state (stall, no timeout).
REQ-016 Edge capturing bit N (count reaches N) completes the word: goes to IDLE (or PARITY with macro).
REQ-017 Word completion: if dout_valid=0, or dout_valid=1 with dout_ready=1 on the same edge, the word is copied to dout and dout_valid=1 from the next cycle.
REQ-018 Word completion with dout_valid=1 and dout_ready=0: new word discarded, dout unchanged, overrun=1 for exactly the next cycle.
REQ-019 Latency: dout_valid rises the cycle after the edge sampling the last data bit (last parity bit with macro).
REQ-020 dout_valid clears on an edge with dout_ready=1 unless REQ-017 reloads on the same edge; dout_ready ignored while dout_valid=0.
REQ-021 start=1, sin_en=1 in SHIFT or PARITY: current frame aborted silently (no dout update, no overrun), bit loaded as new MSB, count=1, state SHIFT.
REQ-022 Back-to-back frames: start on the cycle immediately after a completing edge is accepted with no gap cycle.
REQ-023 Pairs with the team's MSB-first PISO: start asserted on the first shifted bit (cycle after its load), sin_en=1 for N cycles recovers the loaded word exactly.
REQ-024 busy=1 exactly in SHIFT/PARITY; count width ceil(log2(N+1)), never wraps past N.

Reset
REQ-025 rst=0 at a clock edge: state IDLE, count 0, shift register 0, dout 0, dout_valid 0, overrun 0, busy 0, parity_err 0.
REQ-026 Reset mid-frame or with dout_valid=1 discards all partial and pending data; no overrun pulse.
REQ-027 Reset takes priority over start, sin_en and dout_ready on the same edge.
REQ-028 First frame is accepted on the first edge with rst=1.

Configuration
REQ-029 Macro SIPO_RX_PARITY_EN selects parity checking; without it: no PARITY state, no parity_err port, frame is exactly N bits.
REQ-030 With SIPO_RX_PARITY_EN: after bit N, state PARITY samples one extra bit (sin_en-qualified); even parity over N data bits plus parity bit; word completes on that edge per REQ-017/018.
REQ-031 parity_err loads with dout (1 = mismatch) and shares dout_valid's lifetime; a discarded word does not affect it.

Verification
REQ-032 N=8, start+sin_en with bits 1,0,1,1,0,0,1,0 over 8 cycles, dout_ready=1 -> dout=8'hB2, dout_valid high one cycle, one cycle after the 8th bit.
REQ-033 N=8, frame 8'hA5 with sin_en=0 for 3 cycles after bit 4 -> dout=8'hA5 after 11 cycles, busy high throughout.
REQ-034 N=8, dout_ready=0, frames 8'h3C then 8'hC3 back-to-back -> dout stays 8'h3C, overrun pulses once after the 8'hC3 last bit; dout_ready=1 then clears dout_valid.
REQ-035 N=8, start reasserted at bit 5 of frame 8'hFF, then frame 8'h01 -> only dout=8'h01 delivered, no overrun.
REQ-036 rst=0 at bit 6 of a frame, then rst=1 and frame 8'h5A -> dout_valid stays 0 until dout=8'h5A.
REQ-037 SIPO_RX_PARITY_EN, N=8, 8'h07 with parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1.
